// File: rtl/delay_line_pipe_pkg.sv
// Shared definitions for the delay-line pipeline blocks.
// Contents: default geometry constants and the tap-select clamp helper,
// which other tap-select blocks can reuse.
package pipe_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned DEFAULT_DEPTH = 4;

  // Map a requested latency onto a legal tap: 0 -> 1, above depth -> depth.
  function automatic int unsigned clamp_delay(input int unsigned sel,
                                              input int unsigned depth);
    if (sel == 0) begin
      return 1;
    end else if (sel > depth) begin
      return depth;
    end else begin
      return sel;
    end
  endfunction

endpackage

// File: rtl/delay_line_pipe_stage.sv
// One {valid, data} register of the delay line.
// Ports:
//   clk, reset      - clock and asynchronous active-high reset
//   en, flush       - shift enable and synchronous clear (flush wins)
//   i_valid, i_data - word from the previous stage
//   o_valid, o_data - stored word
module delay_stage
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // Stage register: reset > flush > enable > hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (en) begin
      r_valid <= i_valid;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/delay_line_pipe.sv
// Multi-stage delay line for a data word plus valid bit, with stall,
// synchronous flush, runtime-selectable output tap and a busy flag.
// Ports:
//   clk, reset          - clock and asynchronous active-high reset
//   en                  - shift enable; 0 holds every stage
//   flush               - synchronous clear of every stage
//   delay               - selected latency (0 -> 1, >DEPTH -> DEPTH)
//   in_valid, in_data   - input word; invalid words enter as zero bubbles
//   out_valid, out_data - word at the selected tap (from registers only)
//   busy                - any stage 1..DEPTH holds a valid word
module delay_line_pipe
  import pipe_pkg::*;
#(
  parameter  int unsigned WIDTH = DEFAULT_WIDTH,
  parameter  int unsigned DEPTH = DEFAULT_DEPTH,
  localparam int unsigned DW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic [DW-1:0]    delay,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  // Index 0 is the (gated) input, index k is the output of stage k.
  logic [DEPTH:0]   w_valid;
  logic [WIDTH-1:0] w_data     [DEPTH+1];
  logic [DEPTH:0]   w_hit;
  logic [DEPTH:0]   w_tap_valid;
  logic [WIDTH-1:0] w_tap_data [DEPTH+1];
  int unsigned      w_eff;

  // Zero the data of bubbles so stale data never travels down the line.
  assign w_valid[0]     = in_valid;
  assign w_data[0]      = in_valid ? in_data : '0;
  assign w_hit[0]       = 1'b0;
  assign w_tap_valid[0] = 1'b0;
  assign w_tap_data[0]  = '0;

  assign w_eff = clamp_delay(32'(delay), DEPTH);

  for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
    delay_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk     (clk),
      .reset   (reset),
      .en      (en),
      .flush   (flush),
      .i_valid (w_valid[k-1]),
      .i_data  (w_data[k-1]),
      .o_valid (w_valid[k]),
      .o_data  (w_data[k])
    );

    // One-hot AND-OR tap mux, accumulated along the chain.
    assign w_hit[k]       = (w_eff == 32'(k));
    assign w_tap_valid[k] = w_tap_valid[k-1] | (w_hit[k] & w_valid[k]);
    assign w_tap_data[k]  = w_tap_data[k-1] | (w_hit[k] ? w_data[k] : '0);
  end

  assign out_valid = w_tap_valid[DEPTH];
  assign out_data  = w_tap_data[DEPTH];
  assign busy      = |w_valid[DEPTH:1];

endmodule

// File: tb/tb_delay_line_pipe.sv
// Self-checking bench for delay_line_pipe: table vectors, directed corner
// sequences and randomized traffic against an array-based reference model.
module tb_delay_line_pipe;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic             flush;
  logic [DW-1:0]    delay;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  // Reference model: plain array of stage contents.
  logic             mv [1:DEPTH];
  logic [WIDTH-1:0] md [1:DEPTH];

  typedef struct {
    logic             en;
    logic             flush;
    logic [DW-1:0]    dly;
    logic             iv;
    logic [WIDTH-1:0] id;
    logic             ev;
    logic [WIDTH-1:0] ed;
    logic             eb;
  } vec_t;

  vec_t vt [10];

  delay_line_pipe #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .flush     (flush),
    .delay     (delay),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 1; k <= int'(DEPTH); k++) begin
      mv[k] = 1'b0;
      md[k] = '0;
    end
  endtask

  task automatic model_edge();
    if (flush) begin
      model_clear();
    end else if (en) begin
      for (int k = int'(DEPTH); k >= 2; k--) begin
        mv[k] = mv[k-1];
        md[k] = md[k-1];
      end
      mv[1] = in_valid;
      md[1] = in_valid ? in_data : '0;
    end
  endtask

  task automatic chk_model(input string name);
    int          e;
    logic        ev;
    logic [WIDTH-1:0] ed;
    logic        eb;
    e = (delay == 0) ? 1 : (int'(delay) > int'(DEPTH)) ? int'(DEPTH) : int'(delay);
    ev = 1'b0;
    ed = '0;
    eb = 1'b0;
    for (int k = 1; k <= int'(DEPTH); k++) begin
      if (k == e) begin
        ev = mv[k];
        ed = md[k];
      end
      eb = eb | mv[k];
    end
    chk({name, ".valid"}, 32'(out_valid), 32'(ev));
    chk({name, ".data"},  32'(out_data),  32'(ed));
    chk({name, ".busy"},  32'(busy),      32'(eb));
  endtask

  task automatic expect_out(input string name, input logic v, input logic [WIDTH-1:0] d,
                            input logic b);
    chk({name, ".valid"}, 32'(out_valid), 32'(v));
    chk({name, ".data"},  32'(out_data),  32'(d));
    chk({name, ".busy"},  32'(busy),      32'(b));
  endtask

  task automatic drive(input logic e, input logic f, input logic [DW-1:0] d,
                       input logic v, input logic [WIDTH-1:0] x);
    en       = e;
    flush    = f;
    delay    = d;
    in_valid = v;
    in_data  = x;
  endtask

  // Advance one rising edge, keep the model in step, settle for sampling.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    // Basic latency at delay=2, then bubbles at delay=1.
    vt[0] = '{1'b1, 1'b0, 3'd2, 1'b1, 8'h11, 1'b0, 8'h00, 1'b1};
    vt[1] = '{1'b1, 1'b0, 3'd2, 1'b1, 8'h22, 1'b1, 8'h11, 1'b1};
    vt[2] = '{1'b1, 1'b0, 3'd2, 1'b1, 8'h33, 1'b1, 8'h22, 1'b1};
    vt[3] = '{1'b1, 1'b0, 3'd2, 1'b0, 8'h00, 1'b1, 8'h33, 1'b1};
    vt[4] = '{1'b1, 1'b0, 3'd2, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1};
    vt[5] = '{1'b1, 1'b0, 3'd2, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1};
    vt[6] = '{1'b1, 1'b0, 3'd2, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    vt[7] = '{1'b1, 1'b0, 3'd1, 1'b1, 8'h10, 1'b1, 8'h10, 1'b1};
    vt[8] = '{1'b1, 1'b0, 3'd1, 1'b0, 8'hEE, 1'b0, 8'h00, 1'b1};
    vt[9] = '{1'b1, 1'b0, 3'd1, 1'b1, 8'h30, 1'b1, 8'h30, 1'b1};

    reset = 1'b0;
    drive(1'b0, 1'b0, 3'd2, 1'b0, 8'h00);
    model_clear();
    #2 reset = 1'b1;
    #1;
    expect_out("reset_state", 1'b0, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      drive(vt[i].en, vt[i].flush, vt[i].dly, vt[i].iv, vt[i].id);
      step();
      expect_out($sformatf("vec%0d", i), vt[i].ev, vt[i].ed, vt[i].eb);
    end

    // Drain, then stall: 0xA5 at delay=3 with two stall edges -> 5 edges.
    drive(1'b1, 1'b1, 3'd3, 1'b0, 8'h00);
    step();
    drive(1'b1, 1'b0, 3'd3, 1'b1, 8'hA5);
    step();
    expect_out("stall_accept", 1'b0, 8'h00, 1'b1);
    drive(1'b0, 1'b0, 3'd3, 1'b1, 8'h77);
    for (int i = 0; i < 2; i++) begin
      step();
      expect_out($sformatf("stall_hold%0d", i), 1'b0, 8'h00, 1'b1);
    end
    drive(1'b1, 1'b0, 3'd3, 1'b0, 8'h00);
    step();
    expect_out("stall_edge4", 1'b0, 8'h00, 1'b1);
    step();
    expect_out("stall_edge5", 1'b1, 8'hA5, 1'b1);

    // Flush priority over a simultaneous valid input.
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 1'b0, 3'd4, 1'b1, 8'(i));
      step();
    end
    expect_out("flush_filled", 1'b1, 8'h01, 1'b1);
    drive(1'b1, 1'b1, 3'd4, 1'b1, 8'hFF);
    step();
    expect_out("flush_now", 1'b0, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 3'd4, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      step();
      expect_out($sformatf("flush_after%0d", i), 1'b0, 8'h00, 1'b0);
    end

    // Clamp: delay=0 behaves as 1, delay=7 behaves as DEPTH.
    drive(1'b1, 1'b0, 3'd0, 1'b1, 8'h5C);
    step();
    expect_out("clamp0", 1'b1, 8'h5C, 1'b1);
    drive(1'b1, 1'b1, 3'd7, 1'b0, 8'h00);
    step();
    drive(1'b1, 1'b0, 3'd7, 1'b1, 8'h5C);
    step();
    drive(1'b1, 1'b0, 3'd7, 1'b0, 8'h00);
    for (int i = 2; i <= 4; i++) begin
      expect_out($sformatf("clamp7_pre%0d", i), 1'b0, 8'h00, 1'b1);
      step();
    end
    expect_out("clamp7_hit", 1'b1, 8'h5C, 1'b1);

    // Asynchronous reset between edges with three words in flight.
    drive(1'b1, 1'b0, 3'd1, 1'b1, 8'h41);
    step();
    drive(1'b1, 1'b0, 3'd1, 1'b1, 8'h42);
    step();
    drive(1'b1, 1'b0, 3'd1, 1'b1, 8'h43);
    step();
    expect_out("areset_pre", 1'b1, 8'h43, 1'b1);
    drive(1'b1, 1'b0, 3'd2, 1'b0, 8'h00);
    #3 reset = 1'b1;
    #1;
    model_clear();
    expect_out("areset_now", 1'b0, 8'h00, 1'b0);
    #1 reset = 1'b0;
    drive(1'b1, 1'b0, 3'd2, 1'b1, 8'h99);
    step();
    expect_out("areset_rel1", 1'b0, 8'h00, 1'b1);
    drive(1'b1, 1'b0, 3'd2, 1'b0, 8'h00);
    step();
    expect_out("areset_rel2", 1'b1, 8'h99, 1'b1);

    // Randomized traffic, including live delay changes, against the model.
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 24) == 0),
            DW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            WIDTH'($urandom_range(0, 255)));
      step();
      chk_model($sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
